// File: rtl/mem_access_sequencer_if.sv
// Bundle of MEM-stage pipeline, data-memory and loader signals around the
// memory access sequencer; slave is the sequencer's view, master the surroundings.
interface mem_access_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [19:0]       instr_in;
    logic              instr_valid;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic [DATA_W-1:0] input_data;
    logic              stall_out;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;

    modport master (
        output instr_in, instr_valid, addr_in, wdata_in, input_data,
               mem_rdata, ld_req, ld_addr, ld_wdata,
        input  stall_out, mem_req, mem_we, mem_addr, mem_wdata,
               load_data, load_valid, ld_gnt
    );

    modport slave (
        input  instr_in, instr_valid, addr_in, wdata_in, input_data,
               mem_rdata, ld_req, ld_addr, ld_wdata,
        output stall_out, mem_req, mem_we, mem_addr, mem_wdata,
               load_data, load_valid, ld_gnt
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// MEM-stage sequencer: single-cycle writes, multi-cycle stalled reads, and a
// bounded-wait arbiter that hands idle memory cycles to the external loader.
module mem_access_sequencer #(
    parameter int          DATA_W     = 16,
    parameter int          ADDR_W     = 16,
    parameter int          MEM_LAT    = 2,
    parameter int          STARVE_MAX = 4,
    parameter logic [3:0]  OP_LOAD    = 4'b1011,
    parameter logic [3:0]  OP_STORE   = 4'b1100,
    parameter logic [3:0]  OP_COPYIN  = 4'b1111
) (
    input  logic                   clock,
    input  logic                   reset,
    mem_access_sequencer_if.slave  bus
);

    typedef enum logic {IDLE, READ_WAIT} state_t;

    state_t            state, state_nxt;
    logic [3:0]        lat_cnt, lat_nxt;
    logic [3:0]        wait_cnt, wait_nxt;

    logic [3:0]        opcode;
    logic              is_load, is_store, is_copyin, pipe_op, starved;

    logic              stall, req, we, valid, gnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, ldata;

    assign opcode    = bus.instr_in[19:16];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_copyin = (opcode == OP_COPYIN);
    assign pipe_op   = bus.instr_valid && (is_load || is_store || is_copyin);
    assign starved   = (wait_cnt == 4'(STARVE_MAX));

    always_comb begin
        // NOTE: every output and next-state value gets a default here, so no
        // path through the case below can leave one unassigned and infer a latch.
        state_nxt = state;
        lat_nxt   = lat_cnt;
        stall     = 1'b0;
        req       = 1'b0;
        we        = 1'b0;
        valid     = 1'b0;
        gnt       = 1'b0;
        addr      = '0;
        wdata     = '0;
        ldata     = '0;

        // Outputs are forced low while reset is held, whatever the inputs do.
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (bus.ld_req && (starved || !pipe_op)) begin
                        gnt   = 1'b1;
                        req   = 1'b1;
                        we    = 1'b1;
                        addr  = bus.ld_addr;
                        wdata = bus.ld_wdata;
                        stall = pipe_op;
                    end else if (pipe_op) begin
                        req  = 1'b1;
                        addr = bus.addr_in;
                        if (is_load) begin
                            stall     = 1'b1;
                            state_nxt = READ_WAIT;
                            lat_nxt   = 4'(MEM_LAT - 1);
                        end else begin
                            we    = 1'b1;
                            wdata = is_copyin ? bus.input_data : bus.wdata_in;
                        end
                    end
                end
                READ_WAIT: begin
                    if (lat_cnt != 4'd0) begin
                        stall   = 1'b1;
                        lat_nxt = lat_cnt - 4'd1;
                    end else begin
                        valid     = 1'b1;
                        ldata     = bus.mem_rdata;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Starvation counter saturates so the priority condition stays true until granted.
        if (!bus.ld_req || gnt)
            wait_nxt = 4'd0;
        else if (!starved)
            wait_nxt = wait_cnt + 4'd1;
        else
            wait_nxt = wait_cnt;
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state    <= IDLE;
            lat_cnt  <= 4'd0;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    assign bus.stall_out  = stall;
    assign bus.mem_req    = req;
    assign bus.mem_we     = we;
    assign bus.mem_addr   = addr;
    assign bus.mem_wdata  = wdata;
    assign bus.load_data  = ldata;
    assign bus.load_valid = valid;
    assign bus.ld_gnt     = gnt;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench: directed literal cases, then randomized traffic compared
// every cycle against a cycle-count based reference model and a memory model.
module tb_mem_access_sequencer;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam logic [3:0] OP_LOAD   = 4'b1011;
    localparam logic [3:0] OP_STORE  = 4'b1100;
    localparam logic [3:0] OP_COPYIN = 4'b1111;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mem_access_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_access_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX),
        .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE), .OP_COPYIN(OP_COPYIN)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment memory: answers a read only MEM_LAT cycles after the request.
    logic [DATA_W-1:0] env_mem [256];
    logic [7:0]        rd_addr = 8'd0;
    int                rd_age  = 100;

    always @(posedge clock) begin
        if (bus.mem_req && bus.mem_we) env_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        if (bus.mem_req && !bus.mem_we) begin
            rd_addr <= bus.mem_addr[7:0];
            rd_age  <= 1;
        end else if (rd_age < 1000) begin
            rd_age  <= rd_age + 1;
        end
    end

    assign bus.mem_rdata = (rd_age == MEM_LAT) ? env_mem[rd_addr] : 16'hDEAD;

    // Reference model: a load is tracked by the cycle it was issued in.
    logic [DATA_W-1:0] model_mem [256];
    int                cyc = 0;
    bit                m_busy = 1'b0;
    int                m_start = 0;
    logic [7:0]        m_laddr = 8'd0;
    int                m_wait = 0;
    bit                m_stall_q = 1'b0;
    bit                m_gnt_q = 1'b0;

    logic              e_stall, e_req, e_we, e_valid, e_gnt;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_ldata;

    always @(negedge clock) begin
        logic [3:0] op;
        bit         is_op;
        e_stall = 0; e_req = 0; e_we = 0; e_valid = 0; e_gnt = 0;
        e_addr = '0; e_wdata = '0; e_ldata = '0;
        op    = bus.instr_in[19:16];
        is_op = bus.instr_valid && (op == OP_LOAD || op == OP_STORE || op == OP_COPYIN);
        if (reset) begin
            m_busy = 0;
            m_wait = 0;
        end else begin
            if (m_busy) begin
                if (cyc - m_start < MEM_LAT) begin
                    e_stall = 1;
                end else begin
                    e_valid = 1;
                    e_ldata = model_mem[m_laddr];
                    m_busy  = 0;
                end
            end else if (bus.ld_req && (m_wait >= STARVE_MAX || !is_op)) begin
                e_gnt = 1; e_req = 1; e_we = 1;
                e_addr = bus.ld_addr; e_wdata = bus.ld_wdata; e_stall = is_op;
            end else if (is_op) begin
                e_req  = 1;
                e_addr = bus.addr_in;
                if (op == OP_LOAD) begin
                    e_stall = 1;
                    m_busy  = 1;
                    m_start = cyc;
                    m_laddr = bus.addr_in[7:0];
                end else begin
                    e_we    = 1;
                    e_wdata = (op == OP_COPYIN) ? bus.input_data : bus.wdata_in;
                end
            end
            if (!bus.ld_req || e_gnt) m_wait = 0;
            else if (m_wait < STARVE_MAX) m_wait = m_wait + 1;
        end

        check("stall_out",  32'(bus.stall_out),  32'(e_stall));
        check("mem_req",    32'(bus.mem_req),    32'(e_req));
        check("mem_we",     32'(bus.mem_we),     32'(e_we));
        check("mem_addr",   32'(bus.mem_addr),   32'(e_addr));
        check("mem_wdata",  32'(bus.mem_wdata),  32'(e_wdata));
        check("load_valid", 32'(bus.load_valid), 32'(e_valid));
        check("load_data",  32'(bus.load_data),  32'(e_ldata));
        check("ld_gnt",     32'(bus.ld_gnt),     32'(e_gnt));

        if (e_req && e_we) model_mem[e_addr[7:0]] = e_wdata;
        m_stall_q = e_stall;
        m_gnt_q   = e_gnt;
        cyc++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input bit vld, input logic [15:0] a,
                             input logic [15:0] wd);
        bus.instr_in    = {op, 16'h0000};
        bus.instr_valid = vld;
        bus.addr_in     = a;
        bus.wdata_in    = wd;
    endtask

    task automatic new_instr();
        int sel;
        logic [3:0] op;
        sel = $urandom_range(0, 9);
        if (sel < 3)      op = OP_LOAD;
        else if (sel < 6) op = OP_STORE;
        else if (sel < 8) op = OP_COPYIN;
        else              op = 4'($urandom_range(0, 10));
        bus.instr_in    = {op, 16'($urandom)};
        bus.instr_valid = ($urandom_range(0, 7) != 0);
        bus.addr_in     = 16'($urandom_range(0, 31));
        bus.wdata_in    = 16'($urandom);
        bus.input_data  = 16'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i]   = 16'(i * 3 + 1);
            model_mem[i] = 16'(i * 3 + 1);
        end
        set_instr(OP_STORE, 1'b1, 16'h0005, 16'h7777);
        bus.input_data = 16'h0000;
        bus.ld_req     = 1'b1;
        bus.ld_addr    = 16'h0009;
        bus.ld_wdata   = 16'h9999;

        // Reset holds every output low even with live requests on the inputs.
        @(negedge clock);
        check("rst_mem_req", 32'(bus.mem_req),   32'd0);
        check("rst_ld_gnt",  32'(bus.ld_gnt),    32'd0);
        check("rst_addr",    32'(bus.mem_addr),  32'd0);
        check("rst_stall",   32'(bus.stall_out), 32'd0);

        tick();
        reset = 1'b0;
        bus.ld_req = 1'b0;
        set_instr(OP_STORE, 1'b1, 16'h0010, 16'hBEEF);
        @(negedge clock);
        check("st_req",   32'(bus.mem_req),   32'd1);
        check("st_we",    32'(bus.mem_we),    32'd1);
        check("st_addr",  32'(bus.mem_addr),  32'h0010);
        check("st_wdata", 32'(bus.mem_wdata), 32'hBEEF);
        check("st_stall", 32'(bus.stall_out), 32'd0);

        tick();
        set_instr(OP_COPYIN, 1'b1, 16'h0011, 16'hFFFF);
        bus.input_data = 16'h1234;
        @(negedge clock);
        check("cp_wdata", 32'(bus.mem_wdata), 32'h1234);
        check("cp_we",    32'(bus.mem_we),    32'd1);

        tick();
        set_instr(OP_STORE, 1'b1, 16'h0020, 16'hCAFE);
        tick();
        set_instr(OP_LOAD, 1'b1, 16'h0020, 16'h0000);
        @(negedge clock);
        check("ld0_req",   32'(bus.mem_req),   32'd1);
        check("ld0_we",    32'(bus.mem_we),    32'd0);
        check("ld0_stall", 32'(bus.stall_out), 32'd1);
        check("ld0_addr",  32'(bus.mem_addr),  32'h0020);
        tick();
        @(negedge clock);
        check("ld1_stall", 32'(bus.stall_out),  32'd1);
        check("ld1_valid", 32'(bus.load_valid), 32'd0);
        tick();
        @(negedge clock);
        check("ld2_stall", 32'(bus.stall_out),  32'd0);
        check("ld2_valid", 32'(bus.load_valid), 32'd1);
        check("ld2_data",  32'(bus.load_data),  32'hCAFE);

        // Loader held against continuous stores: granted on the 5th cycle.
        tick();
        set_instr(OP_STORE, 1'b1, 16'h0030, 16'h1111);
        bus.ld_req   = 1'b1;
        bus.ld_addr  = 16'h0077;
        bus.ld_wdata = 16'h5555;
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            check("starve_gnt", 32'(bus.ld_gnt),   32'd0);
            check("starve_adr", 32'(bus.mem_addr), 32'h0030);
            tick();
        end
        @(negedge clock);
        check("prio_gnt",   32'(bus.ld_gnt),    32'd1);
        check("prio_stall", 32'(bus.stall_out), 32'd1);
        check("prio_addr",  32'(bus.mem_addr),  32'h0077);
        check("prio_wdata", 32'(bus.mem_wdata), 32'h5555);
        tick();
        bus.ld_req = 1'b0;
        @(negedge clock);
        check("retry_req",   32'(bus.mem_req),   32'd1);
        check("retry_addr",  32'(bus.mem_addr),  32'h0030);
        check("retry_stall", 32'(bus.stall_out), 32'd0);

        tick();
        set_instr(4'b0001, 1'b1, 16'h0031, 16'h2222);
        bus.ld_req  = 1'b1;
        bus.ld_addr = 16'h0042;
        @(negedge clock);
        check("nop_gnt",   32'(bus.ld_gnt),    32'd1);
        check("nop_stall", 32'(bus.stall_out), 32'd0);

        // Reset in the middle of a load: the load must be abandoned.
        tick();
        bus.ld_req = 1'b0;
        set_instr(OP_LOAD, 1'b1, 16'h0020, 16'h0000);
        tick();
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        @(negedge clock);
        check("rstld_valid", 32'(bus.load_valid), 32'd0);
        tick();
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            check("abandon_valid", 32'(bus.load_valid), 32'd0);
            tick();
        end
        set_instr(OP_LOAD, 1'b1, 16'h0077, 16'h0000);
        @(negedge clock);
        check("rel0_stall", 32'(bus.stall_out), 32'd1);
        tick();
        @(negedge clock);
        check("rel1_stall", 32'(bus.stall_out), 32'd1);
        tick();
        @(negedge clock);
        check("rel2_valid", 32'(bus.load_valid), 32'd1);
        check("rel2_data",  32'(bus.load_data),  32'h5555);
        tick();
        bus.instr_valid = 1'b0;

        // Randomized traffic: stalled instructions and ungranted loader requests are held.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            if (!m_stall_q) new_instr();
            if (!bus.ld_req || m_gnt_q) begin
                bus.ld_req   = ($urandom_range(0, 2) == 0);
                bus.ld_addr  = 16'($urandom_range(0, 31));
                bus.ld_wdata = 16'($urandom);
            end
        end

        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
